sr_ff_cmd_ctrl: RTL and testbench

Upstream command controller for the `sr_ff` set/reset flip-flop. It turns single-cycle commands (hold, set, reset, toggle) into clean, width-controlled `s`/`r` drive pulses and never presents `s=r=1`. It then watches the flip-flop's `q` feedback to confirm the state change, and reports completion or a verify error. The flip-flop shares `clk`.

---
 rtl/sr_ff_cmd_ctrl_if.sv | 28 ++
 rtl/sr_ff_cmd_ctrl.sv | 117 +++++++++++
 tb/tb_sr_ff_cmd_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_ff_cmd_ctrl_if.sv
// Command handshake and completion status between a master and
// the sr_ff command controller.
interface sr_ff_cmd_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       done;
    logic       err;
    logic [7:0] err_cnt;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready,
        input  done,
        input  err,
        input  err_cnt
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready,
        output done,
        output err,
        output err_cnt
    );
endinterface

// File: rtl/sr_ff_cmd_ctrl.sv
// Turns hold/set/reset/toggle commands into width-controlled s/r pulses
// for an sr_ff, then verifies q and reports done/err.
module sr_ff_cmd_ctrl #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned CHECK_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    sr_ff_cmd_ctrl_if.slave cmd,
    input  logic            q,
    output logic            s,
    output logic            r
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] PW_LAST = 8'(PULSE_W - 1);
    localparam logic [7:0] CW_LAST = 8'(CHECK_W - 1);

    state_t     state;
    logic       target;
    logic       hold;
    logic [7:0] cnt;
    logic       done_q;
    logic       err_q;
    logic [7:0] err_cnt_q;
    logic       next_target;

    always_comb begin
        next_target = q;
        unique case (cmd.cmd_op)
            2'b01:   next_target = 1'b1;
            2'b10:   next_target = 1'b0;
            2'b11:   next_target = ~q;
            default: next_target = q;
        endcase
    end

    // A hold spends one cycle in CHECK with a forced match so that
    // its completion lands one edge after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= 1'b0;
            r         <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            target    <= 1'b0;
            hold      <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        cnt    <= 8'd0;
                        target <= next_target;
                        hold   <= (cmd.cmd_op == 2'b00);
                        if (cmd.cmd_op == 2'b00) begin
                            state <= CHECK;
                        end else begin
                            state <= DRIVE;
                            s     <= next_target;
                            r     <= ~next_target;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == PW_LAST) begin
                        state <= CHECK;
                        s     <= 1'b0;
                        r     <= 1'b0;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CHECK: begin
                    if (hold || (q == target)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else if (cnt == CW_LAST) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    s     <= 1'b0;
                    r     <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (state == IDLE) & ~rst;
    assign cmd.done      = done_q;
    assign cmd.err       = err_q;
    assign cmd.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sr_ff_cmd_ctrl.sv
// Bench for sr_ff_cmd_ctrl: directed vector table, corner sequences and
// randomized traffic against a transaction-timing reference model.
module tb_sr_ff_cmd_ctrl;

    localparam int PW = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_ff_cmd_ctrl_if bus ();

    logic s, r, q;
    logic ffq   = 1'b0;
    logic stuck = 1'b0;

    // Behavioural sr_ff; "stuck" forces its visible output low.
    always @(posedge clk) begin
        if (s === 1'b1) ffq <= 1'b1;
        else if (r === 1'b1) ffq <= 1'b0;
    end
    assign q = stuck ? 1'b0 : ffq;

    sr_ff_cmd_ctrl #(.PULSE_W(PW), .CHECK_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .cmd (bus),
        .q   (q),
        .s   (s),
        .r   (r)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if (s === 1'b1 && r === 1'b1) begin
            failures++;
            $display("FAIL s_r_overlap: got s=1 r=1 expected not both (cycle %0d)", cyc);
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("ready_timeout", 0, 1);
    endtask

    task automatic run_cmd(input logic [1:0] op, output int lat,
                           output logic e, output int ns, output int nr,
                           output int dcyc);
        lat = -1; e = 1'b0; ns = 0; nr = 0; dcyc = 0;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (s === 1'b1) ns++;
            if (r === 1'b1) nr++;
            if (bus.done === 1'b1) begin
                lat  = i;
                e    = bus.err;
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk("done_width", bus.done, 0);
        chk("ready_after_done", bus.cmd_ready, 1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic       stk;
        int         lat;
        logic       e;
        logic       qa;
        int         ns;
        int         nr;
        int         ec;
    } vec_t;

    vec_t tbl[11];
    int   dc[11];

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lat, ns, nr, dcyc, nd, acc, nerr;
        logic e;
        logic active, terr, ttgt, mq, qe, mcnt_dummy;
        logic e_s, e_r, e_done, e_err, e_rdy;
        logic [1:0] top;
        int rel, done_at, mcnt;

        tbl[0]  = '{2'b01, 1'b0, 3, 1'b0, 1'b1, 2, 0, 0};
        tbl[1]  = '{2'b01, 1'b0, 3, 1'b0, 1'b1, 2, 0, 0};
        tbl[2]  = '{2'b00, 1'b0, 1, 1'b0, 1'b1, 0, 0, 0};
        tbl[3]  = '{2'b10, 1'b0, 3, 1'b0, 1'b0, 0, 2, 0};
        tbl[4]  = '{2'b11, 1'b0, 3, 1'b0, 1'b1, 2, 0, 0};
        tbl[5]  = '{2'b11, 1'b0, 3, 1'b0, 1'b0, 0, 2, 0};
        tbl[6]  = '{2'b01, 1'b1, 6, 1'b1, 1'b0, 2, 0, 1};
        tbl[7]  = '{2'b10, 1'b1, 3, 1'b0, 1'b0, 0, 2, 1};
        tbl[8]  = '{2'b11, 1'b1, 6, 1'b1, 1'b0, 2, 0, 2};
        tbl[9]  = '{2'b00, 1'b1, 1, 1'b0, 1'b0, 0, 0, 2};
        tbl[10] = '{2'b11, 1'b0, 3, 1'b0, 1'b0, 0, 2, 2};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        chk("rst_ready_low", bus.cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready_high", bus.cmd_ready, 1);

        for (int i = 0; i < 11; i++) begin
            stuck = tbl[i].stk;
            run_cmd(tbl[i].op, lat, e, ns, nr, dcyc);
            dc[i] = dcyc;
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
            chk($sformatf("tbl%0d_q", i), q, tbl[i].qa);
            chk($sformatf("tbl%0d_s_cycles", i), ns, tbl[i].ns);
            chk($sformatf("tbl%0d_r_cycles", i), nr, tbl[i].nr);
            chk($sformatf("tbl%0d_err_cnt", i), bus.err_cnt, tbl[i].ec);
        end
        chk("b2b_spacing_a", dc[4] - dc[3], PW + 3);
        chk("b2b_spacing_b", dc[5] - dc[4], PW + 3);

        // Reset in the middle of a set pulse.
        stuck = 1'b0;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("mid_s_before_rst", s, 1);
        rst = 1'b1;
        #1;
        chk("mid_ready_in_rst", bus.cmd_ready, 0);
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
            if (i == 0) begin
                chk("mid_rst_s", s, 0);
                chk("mid_rst_r", r, 0);
            end
        end
        chk("mid_rst_no_done", nd, 0);
        chk("mid_rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready_after", bus.cmd_ready, 1);
        chk("mid_done_after", bus.done, 0);

        // Redundant set, then a reset held while busy.
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        @(negedge clk);
        bus.cmd_op = 2'b10;
        nd = 0; ns = 0; nr = 0; acc = 0;
        for (int i = 0; i < 14; i++) begin
            if (s === 1'b1) ns++;
            if (r === 1'b1) nr++;
            if (bus.done === 1'b1) nd++;
            if (bus.cmd_valid && bus.cmd_ready === 1'b1) acc++;
            @(negedge clk);
            if (acc == 1) bus.cmd_valid = 1'b0;
        end
        chk("ign_accepts", acc, 1);
        chk("ign_done_count", nd, 2);
        chk("ign_s_cycles", ns, PW);
        chk("ign_r_cycles", nr, PW);
        chk("ign_q", q, 0);

        // Error counter saturation with q stuck low.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("sat_start", bus.err_cnt, 0);
        stuck = 1'b1;
        nerr = 0;
        for (int n = 0; n < 260; n++) begin
            run_cmd(2'b01, lat, e, ns, nr, dcyc);
            if (e === 1'b1) nerr++;
            if (n == 0) begin
                chk("sat_lat", lat, PW + CW);
                chk("sat_first_cnt", bus.err_cnt, 1);
            end
            if (n == 253) chk("sat_254", bus.err_cnt, 254);
            if (n == 254) chk("sat_255", bus.err_cnt, 255);
        end
        chk("sat_err_pulses", nerr, 260);
        chk("sat_final", bus.err_cnt, 255);

        // Randomized traffic against the timing model.
        stuck = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_cmd(2'b10, lat, e, ns, nr, dcyc);
        mq = 1'b0; mcnt = 0; active = 1'b0; rel = 0; done_at = 0;
        terr = 1'b0; ttgt = 1'b0; top = 2'b00; mcnt_dummy = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            e_s    = active && top != 2'b00 && rel < PW && ttgt;
            e_r    = active && top != 2'b00 && rel < PW && !ttgt;
            e_done = active && rel == done_at;
            e_err  = e_done && terr;
            if (e_err && mcnt < 255) mcnt++;
            e_rdy  = !active;
            chk("rnd_s", s, e_s);
            chk("rnd_r", r, e_r);
            chk("rnd_done", bus.done, e_done);
            chk("rnd_err", bus.err, e_err);
            chk("rnd_ready", bus.cmd_ready, e_rdy);
            chk("rnd_err_cnt", bus.err_cnt, mcnt);
            if (!active && $urandom_range(7) == 0) stuck = ~stuck;
            bus.cmd_valid = 1'($urandom_range(1));
            bus.cmd_op    = 2'($urandom_range(3));
            if (active) begin
                if (rel == done_at) active = 1'b0;
                else rel++;
            end else if (bus.cmd_valid) begin
                active = 1'b1;
                rel    = 0;
                top    = bus.cmd_op;
                qe     = stuck ? 1'b0 : mq;
                case (top)
                    2'b01:   ttgt = 1'b1;
                    2'b10:   ttgt = 1'b0;
                    2'b11:   ttgt = ~qe;
                    default: ttgt = qe;
                endcase
                if (top == 2'b00) begin
                    done_at = 1;
                    terr    = 1'b0;
                end else begin
                    terr    = ((stuck ? 1'b0 : ttgt) != ttgt);
                    done_at = terr ? PW + CW : PW + 1;
                    mq      = ttgt;
                end
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
